kbd_event_sequencer: RTL

KBD_EVENT_SEQUENCER -- requirements
Module: kbd_event_sequencer

---
 rtl/kbd_pkg.sv | 27 ++
 rtl/ev_fifo.sv | 38 +++
 rtl/kbd_event_sequencer.sv | 75 +++++++
 3 files changed

// File: rtl/kbd_pkg.sv
// kbd_pkg: shared encodings, byte constants and event record for the keyboard sequencer
package kbd_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_GOT_E0, ST_GOT_F0, ST_GOT_E0F0} state_t;
  localparam logic [7:0] B_E0 = 8'hE0;
  localparam logic [7:0] B_F0 = 8'hF0;
  localparam logic [7:0] B_E1 = 8'hE1;
  localparam logic [7:0] B_AA = 8'hAA;
  localparam logic [7:0] B_FA = 8'hFA;
  localparam logic [7:0] B_FE = 8'hFE;
  localparam logic [7:0] B_EE = 8'hEE;
  localparam int EV_W = 11;
  localparam logic [7:0] DIGITS [10] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
                                         8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45};
  typedef struct packed {
    logic       route;
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ev_t;
  function automatic logic is_digit(input logic [7:0] c);
    is_digit = 1'b0;
    for (int i = 0; i < 10; i++) if (c == DIGITS[i]) is_digit = 1'b1;
  endfunction
  function automatic logic is_discard(input logic [7:0] c);
    is_discard = c == B_E1 || c == B_AA || c == B_FA || c == B_FE || c == B_EE;
  endfunction
endpackage

// File: rtl/ev_fifo.sv
// ev_fifo: synchronous event FIFO; a push into a full FIFO is taken only alongside a pop
module ev_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 11
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk) if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/kbd_event_sequencer.sv
// kbd_event_sequencer: folds PS/2 prefix bytes into key events and routes them to display or PWM
module kbd_event_sequencer
  import kbd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT = 50000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          byte_valid,
  input  logic [7:0]                    byte_in,
  input  logic                          disp_ready,
  input  logic                          pwm_ready,
  output logic                          disp_valid,
  output logic                          pwm_valid,
  output logic [7:0]                    ev_code,
  output logic                          ev_break,
  output logic                          ev_ext,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t state;
  logic [TW-1:0] tmo;
  logic is_pre, commit, full, empty, pop;
  ev_t wr_ev, hd_ev;
  always_comb begin
    is_pre = byte_in == B_E0 || byte_in == B_F0;
    commit = byte_valid && !is_pre && (state != ST_IDLE || !is_discard(byte_in));
    wr_ev.ext = state == ST_GOT_E0 || state == ST_GOT_E0F0;
    wr_ev.brk = state == ST_GOT_F0 || state == ST_GOT_E0F0;
    wr_ev.code = byte_in;
    wr_ev.route = !wr_ev.ext && !wr_ev.brk && is_digit(byte_in);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      tmo <= '0;
    end else if (byte_valid) begin
      tmo <= '0;
      state <= state == ST_IDLE ? (byte_in == B_E0 ? ST_GOT_E0 : byte_in == B_F0 ? ST_GOT_F0 : ST_IDLE)
             : state == ST_GOT_E0 ? (byte_in == B_F0 ? ST_GOT_E0F0 : byte_in == B_E0 ? ST_GOT_E0 : ST_IDLE)
             : ST_IDLE;
    end else if (state != ST_IDLE) begin
      // an abandoned prefix returns to IDLE silently after TIMEOUT quiet cycles
      if (tmo == TW'(TIMEOUT - 1)) begin
        state <= ST_IDLE;
        tmo <= '0;
      end else begin
        tmo <= tmo + TW'(1);
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) overflow <= 1'b0;
    else if (commit && full && !pop) overflow <= 1'b1;
  end
  ev_fifo #(.DEPTH(FIFO_DEPTH), .W(EV_W)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(commit),
    .pop(pop),
    .din(wr_ev),
    .dout(hd_ev),
    .count(fifo_count),
    .full(full),
    .empty(empty)
  );
  assign disp_valid = !empty && !hd_ev.route;
  assign pwm_valid = !empty && hd_ev.route;
  assign ev_code = empty ? 8'h00 : hd_ev.code;
  assign ev_break = !empty && hd_ev.brk;
  assign ev_ext = !empty && hd_ev.ext;
  assign pop = (disp_valid && disp_ready) || (pwm_valid && pwm_ready);
endmodule
